// File: rtl/id_ex_skid_pkg.sv
// id_ex_skid_pkg
//   Shared definitions for the ID/EX skid-buffered pipeline register:
//   default widths, the skid-buffer state encoding and a helper that
//   computes the width of the stored instruction bundle.
//   No ports (package).
package id_ex_skid_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 5;
  localparam int DEF_REG_W  = 3;
  localparam int BUBBLE_W   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Stored bundle layout is {op, a, b, rd, wen}.
  function automatic int bundle_width(input int data_w, input int op_w, input int reg_w);
    return op_w + 2 * data_w + reg_w + 1;
  endfunction

endpackage

// File: rtl/id_ex_skid_bundle_reg.sv
// id_ex_bundle_reg
//   Enable-loaded register for one instruction bundle with a synchronous
//   clear. Used twice by id_ex_skid: once as the main (output-driving)
//   entry and once as the skid (overflow) entry.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset, clears the register
//     clr  - synchronous clear, wins over en
//     en   - load d on the next edge
//     d    - bundle to load
//     q    - held bundle
module id_ex_bundle_reg #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clearing takes priority so an emptied entry always reads as zero,
  // which keeps the downstream bundle at zero whenever nothing is valid.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// id_ex_skid
//   ID/EX pipeline register built as a two-entry skid buffer. The decode
//   stage hands over an instruction with a valid/ready handshake; the
//   B operand is selected (register or immediate) before storage. The main
//   entry drives the execute stage, the skid entry absorbs one instruction
//   when execute stalls, so in_ready can be a plain flop.
//   Optional feature: define ID_EX_BUBBLE_CNT_EN to build a saturating
//   counter of cycles in which no instruction is offered to execute.
//   Ports:
//     clk, rst                       - clock, synchronous active-high reset
//     in_valid / in_ready            - decode-side handshake (in_ready registered)
//     in_op, in_rs_data, in_rt_data,
//     in_imm, in_imm_sel, in_rd, in_wen - decoded instruction fields
//     flush                          - drop every held instruction
//     out_valid / out_ready          - execute-side handshake
//     out_op, out_a, out_b,
//     out_rd, out_wen                - execute bundle (zero when not valid)
//     bubble_cnt                     - idle-cycle count (0 when feature off)
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [DATA_W-1:0]   in_rs_data,
  input  logic [DATA_W-1:0]   in_rt_data,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic                in_imm_sel,
  input  logic [REG_W-1:0]    in_rd,
  input  logic                in_wen,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_W-1:0]     out_op,
  output logic [DATA_W-1:0]   out_a,
  output logic [DATA_W-1:0]   out_b,
  output logic [REG_W-1:0]    out_rd,
  output logic                out_wen,
  output logic [BUBBLE_W-1:0] bubble_cnt
);

  localparam int BW = bundle_width(DATA_W, OP_W, REG_W);

  skid_state_e   state;
  skid_state_e   next_state;
  logic          push;
  logic          pop;
  logic          main_load;
  logic          main_from_skid;
  logic          main_clr;
  logic          skid_load;
  logic          skid_clr;
  logic [BW-1:0] in_bundle;
  logic [BW-1:0] main_d;
  logic [BW-1:0] main_q;
  logic [BW-1:0] skid_q;

  // The operand mux sits before storage so both entries hold ALU-ready data.
  assign in_bundle = {in_op, in_rs_data, (in_imm_sel ? in_imm : in_rt_data), in_rd, in_wen};

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State register. in_ready is computed from the next state so it is a
  // flop yet never admits an instruction the buffer cannot hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  // Next-state logic. Flush overrides any transfer in the same cycle.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) next_state = ONE;
        ONE: begin
          if (push && !pop)      next_state = FULL;
          else if (!push && pop) next_state = EMPTY;
        end
        FULL: if (pop) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Output / datapath control. In ONE with push and pop the new
  // instruction goes straight to main; in FULL a pop promotes skid to main.
  always_comb begin
    out_valid      = (state != EMPTY);
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    main_clr       = flush | (next_state == EMPTY);
    skid_clr       = flush;
    unique case (state)
      EMPTY: main_load = push;
      ONE: begin
        main_load = push & pop;
        skid_load = push & ~pop;
      end
      FULL: begin
        main_load      = pop;
        main_from_skid = 1'b1;
        skid_clr       = flush | pop;
      end
      default: main_load = 1'b0;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_bundle;

  id_ex_bundle_reg #(.W(BW)) u_main (
    .clk (clk),
    .rst (rst),
    .clr (main_clr),
    .en  (main_load),
    .d   (main_d),
    .q   (main_q)
  );

  id_ex_bundle_reg #(.W(BW)) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (skid_clr),
    .en  (skid_load),
    .d   (in_bundle),
    .q   (skid_q)
  );

  assign {out_op, out_a, out_b, out_rd, out_wen} = main_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  // Idle-cycle counter: counts every non-reset cycle with nothing offered
  // to execute, and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {BUBBLE_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  assign bubble_cnt = '0;
`endif

endmodule
